axi_sram_slave: RTL

AXI4 slave endpoint that turns read and write bursts arriving from the interconnect into accesses on a single-port, synchronous-read SRAM macro. It sits on each memory slave port of the crossbar. Its AWREADY/ARREADY behaviour is what the crossbar samples when granting a slave, so both are high only while the block is idle. One transaction is in flight at a time; reads and writes never overlap.

---
 rtl/axi_sram_if.sv | 64 ++++++
 rtl/axi_sram_slave.sv | 132 +++++++++++++
 2 files changed

// File: rtl/axi_sram_if.sv
// AXI4 channel bundle between the crossbar (master side) and an SRAM slave port.
interface axi_sram_if #(
  parameter int unsigned IDW = 8
);
  logic [IDW-1:0] AWID;
  logic [31:0]    AWADDR;
  logic [3:0]     AWLEN;
  logic [2:0]     AWSIZE;
  logic [1:0]     AWBURST;
  logic           AWVALID;
  logic           AWREADY;

  logic [31:0]    WDATA;
  logic [3:0]     WSTRB;
  logic           WLAST;
  logic           WVALID;
  logic           WREADY;

  logic [IDW-1:0] BID;
  logic [1:0]     BRESP;
  logic           BVALID;
  logic           BREADY;

  logic [IDW-1:0] ARID;
  logic [31:0]    ARADDR;
  logic [3:0]     ARLEN;
  logic [2:0]     ARSIZE;
  logic [1:0]     ARBURST;
  logic           ARVALID;
  logic           ARREADY;

  logic [IDW-1:0] RID;
  logic [31:0]    RDATA;
  logic [1:0]     RRESP;
  logic           RLAST;
  logic           RVALID;
  logic           RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave that serialises one read or write burst at a time onto a
// single-port synchronous-read SRAM macro.
module axi_sram_slave #(
  parameter int unsigned IDW     = 8,
  parameter int unsigned SRAM_AW = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  axi_sram_if.slave          axi,
  output logic               sram_cs,
  output logic               sram_we,
  output logic [3:0]         sram_bwe,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_DATA = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;

  logic [2:0]         state;
  logic [2:0]         next_state;
  logic [IDW-1:0]     id_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [3:0]         len_q;
  logic [3:0]         beat_q;
  logic               fixed_q;
  logic               err_q;

  logic               last_beat;
  logic               w_hs;
  logic               rd_active;
  logic               wr_resp;
  logic [SRAM_AW-1:0] next_addr;

  assign last_beat = (beat_q == len_q);
  assign w_hs      = (state == S_WR_DATA) && axi.WVALID;
  assign rd_active = (state == S_RD_DATA);
  assign wr_resp   = (state == S_WR_RESP);
  // FIXED holds the word; INCR and WRAP both step and wrap at the top of the macro
  assign next_addr = fixed_q ? addr_q : addr_q + SRAM_AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (axi.ARVALID)      next_state = S_RD_REQ;
        else if (axi.AWVALID) next_state = S_WR_DATA;
      end
      S_RD_REQ:  next_state = S_RD_DATA;
      S_RD_DATA: if (axi.RREADY) next_state = last_beat ? S_IDLE : S_RD_REQ;
      S_WR_DATA: if (axi.WVALID && (axi.WLAST || last_beat)) next_state = S_WR_RESP;
      S_WR_RESP: if (axi.BREADY) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Burst context: latched on address accept, stepped on each data beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      fixed_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (axi.ARVALID) begin
            id_q    <= axi.ARID;
            addr_q  <= axi.ARADDR[SRAM_AW+1:2];
            len_q   <= axi.ARLEN;
            fixed_q <= (axi.ARBURST == 2'b00);
            beat_q  <= '0;
          end else if (axi.AWVALID) begin
            id_q    <= axi.AWID;
            addr_q  <= axi.AWADDR[SRAM_AW+1:2];
            len_q   <= axi.AWLEN;
            fixed_q <= (axi.AWBURST == 2'b00);
            beat_q  <= '0;
          end
        end
        S_RD_DATA: begin
          if (axi.RREADY && !last_beat) begin
            beat_q <= beat_q + 4'd1;
            addr_q <= next_addr;
          end
        end
        S_WR_DATA: begin
          if (axi.WVALID) begin
            beat_q <= beat_q + 4'd1;
            addr_q <= next_addr;
            if (axi.WLAST != last_beat) err_q <= 1'b1;
          end
        end
        S_WR_RESP: if (axi.BREADY) err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign axi.ARREADY = (state == S_IDLE);
  assign axi.AWREADY = (state == S_IDLE);
  assign axi.WREADY  = (state == S_WR_DATA);

  assign axi.BVALID  = wr_resp;
  assign axi.BID     = wr_resp ? id_q : '0;
  assign axi.BRESP   = (wr_resp && err_q) ? 2'b10 : 2'b00;

  // Read data comes straight from the macro, which holds it while no access is issued
  assign axi.RVALID  = rd_active;
  assign axi.RID     = rd_active ? id_q : '0;
  assign axi.RDATA   = rd_active ? sram_rdata : 32'h0;
  assign axi.RRESP   = 2'b00;
  assign axi.RLAST   = rd_active && last_beat;

  assign sram_cs     = (state == S_RD_REQ) || w_hs;
  assign sram_we     = w_hs;
  assign sram_bwe    = w_hs ? axi.WSTRB : 4'h0;
  assign sram_wdata  = w_hs ? axi.WDATA : 32'h0;
  assign sram_addr   = addr_q;

endmodule
